dpr_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the true dual-port RAM between NUM_REQ requesters.
- Each requester issues single-cycle read or write commands with a valid/ready handshake.
- The arbiter drives the RAM port, tags each command, and returns a response one cycle later.
- It sits between client engines and port A (or B) of the RAM; the other RAM port stays independent.

---
 rtl/dpr_port_arbiter_if.sv | 37 +++
 rtl/dpr_port_arbiter.sv | 104 ++++++++++
 tb/tb_dpr_port_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dpr_port_arbiter_if.sv
// rtl/dpr_port_arbiter_if.sv - requester, RAM port and response bundle for dpr_port_arbiter
interface dpr_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    logic                          ram_we;
    logic [ADDR_WIDTH-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0]         ram_data;
    logic [DATA_WIDTH-1:0]         ram_q;

    logic                          rsp_valid;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic                          rsp_we;
    logic [DATA_WIDTH-1:0]         rsp_data;

    // Arbiter side
    modport slave (
        input  req_valid, req_we, req_addr, req_data, ram_q,
        output req_ready, ram_we, ram_addr, ram_data,
        output rsp_valid, rsp_id, rsp_we, rsp_data
    );

    // Requesters plus RAM side
    modport master (
        output req_valid, req_we, req_addr, req_data, ram_q,
        input  req_ready, ram_we, ram_addr, ram_data,
        input  rsp_valid, rsp_id, rsp_we, rsp_data
    );
endinterface

// File: rtl/dpr_port_arbiter.sv
// rtl/dpr_port_arbiter.sv - round-robin, burst-limited arbiter sharing one RAM port
module dpr_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    dpr_port_arbiter_if.slave   bus
);
    localparam int                  CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(BURST_MAX);

    logic [ID_WIDTH-1:0] owner;
    logic [CNT_W-1:0]    cnt;
    logic                has_owner;

    logic                keep;
    logic                search_hit;
    logic [ID_WIDTH-1:0] search_idx;
    logic [ID_WIDTH-1:0] probe;
    logic                grant_any;
    logic [ID_WIDTH-1:0] grant_idx;
    logic                grant_we;

    logic                rsp_valid_q;
    logic [ID_WIDTH-1:0] rsp_id_q;
    logic                rsp_we_q;

    always_comb begin
        keep = rst && has_owner && bus.req_valid[owner] && (cnt < CNT_MAX);
    end

    // The probe visits owner+1 .. owner, so an exhausted sole requester is found last.
    always_comb begin
        probe      = owner;
        search_hit = 1'b0;
        search_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = (probe == LAST_ID) ? '0 : probe + ID_WIDTH'(1);
            if (!search_hit && bus.req_valid[probe]) begin
                search_hit = 1'b1;
                search_idx = probe;
            end
        end
    end

    always_comb begin
        grant_any = rst && (keep || search_hit);
        grant_idx = keep ? owner : search_idx;
        grant_we  = bus.req_we[grant_idx];
    end

    always_comb begin
        bus.req_ready = '0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_data  = '0;
        if (grant_any) begin
            bus.req_ready[grant_idx] = 1'b1;
            bus.ram_we               = grant_we;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_idx == ID_WIDTH'(i)) begin
                    bus.ram_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    bus.ram_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner       <= LAST_ID;
            cnt         <= '0;
            has_owner   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= grant_any;
            rsp_id_q    <= grant_any ? grant_idx : '0;
            rsp_we_q    <= grant_any && grant_we;
            if (grant_any) begin
                owner     <= grant_idx;
                cnt       <= keep ? cnt + CNT_W'(1) : CNT_W'(1);
                has_owner <= 1'b1;
            end else begin
                cnt       <= '0;
                has_owner <= 1'b0;
            end
        end
    end

    // RAM read data is already registered, so the response data needs no extra stage.
    always_comb begin
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_id    = rsp_id_q;
        bus.rsp_we    = rsp_we_q;
        bus.rsp_data  = rsp_valid_q ? bus.ram_q : '0;
    end
endmodule

// File: tb/tb_dpr_port_arbiter.sv
// tb/tb_dpr_port_arbiter.sv - randomized and directed checks of dpr_port_arbiter against a behavioural model
module tb_dpr_port_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 4;
    localparam int BM = 4;
    localparam int IW = $clog2(NR);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dpr_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

    dpr_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .BURST_MAX(BM), .ID_WIDTH(IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Write-first RAM port with registered output
    logic [DW-1:0] ram [2**AW];
    initial begin
        for (int i = 0; i < 2**AW; i++) ram[i] = '0;
        bus.ram_q = '0;
    end
    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_data;
            bus.ram_q         <= bus.ram_data;
        end else begin
            bus.ram_q <= ram[bus.ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int grant_of(input logic [NR-1:0] r);
        int g;
        g = -1;
        for (int i = 0; i < NR; i++) if (r[i]) g = i;
        return g;
    endfunction

    // Behavioural model: last owner, length of its current unbroken run, shadow memory
    int            m_owner = NR - 1;
    int            m_run   = 0;
    logic [DW-1:0] m_mem [2**AW];
    bit            p_valid = 0;
    int            p_id    = 0;
    bit            p_we    = 0;
    logic [DW-1:0] p_data  = '0;
    initial for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;

    always @(negedge clk) begin
        int            g;
        bit            kept;
        int            a;
        logic [DW-1:0] d;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(p_valid));
        if (p_valid) begin
            check("rsp_id", 32'(bus.rsp_id), 32'(p_id));
            check("rsp_we", 32'(bus.rsp_we), 32'(p_we));
        end
        check("rsp_data", 32'(bus.rsp_data), p_valid ? 32'(p_data) : 32'd0);

        g = -1;
        kept = 0;
        if (rst) begin
            if (m_run > 0 && m_run < BM && bus.req_valid[m_owner]) begin
                g = m_owner;
                kept = 1;
            end else begin
                for (int k = 1; k <= NR; k++)
                    if (g < 0 && bus.req_valid[(m_owner + k) % NR]) g = (m_owner + k) % NR;
            end
        end
        a = (g >= 0) ? int'(bus.req_addr[g*AW +: AW]) : 0;
        d = (g >= 0) ? bus.req_data[g*DW +: DW] : '0;
        check("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("ram_we", 32'(bus.ram_we), (g >= 0) ? 32'(bus.req_we[g]) : 32'd0);
        check("ram_addr", 32'(bus.ram_addr), 32'(a));
        check("ram_data", 32'(bus.ram_data), (g >= 0 && bus.req_we[g]) ? 32'(d) : (g >= 0 ? 32'(d) : 32'd0));

        if (!rst) begin
            m_owner = NR - 1;
            m_run   = 0;
            p_valid = 0;
        end else if (g >= 0) begin
            m_run   = kept ? m_run + 1 : 1;
            m_owner = g;
            p_valid = 1;
            p_id    = g;
            p_we    = bus.req_we[g];
            if (bus.req_we[g]) m_mem[a] = d;
            p_data  = m_mem[a];
        end else begin
            m_run   = 0;
            p_valid = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.req_we[i]            = we;
        bus.req_addr[i*AW +: AW] = addr;
        bus.req_data[i*DW +: DW] = data;
    endtask

    initial begin
        bus.req_valid = '1;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(8'h20 + i), DW'(i));

        // Reset with everyone requesting
        repeat (3) begin
            @(negedge clk);
            check("reset_ready", 32'(bus.req_ready), 32'd0);
            check("reset_ram_we", 32'(bus.ram_we), 32'd0);
            check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        check("first_grant_req0", 32'(bus.req_ready), 32'h1);
        next_cycle();

        // Write then read through requester 2
        bus.req_valid = 4'b0100;
        set_req(2, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        check("wr_ready", 32'(bus.req_ready), 32'h4);
        check("wr_ram_we", 32'(bus.ram_we), 32'd1);
        check("wr_ram_addr", 32'(bus.ram_addr), 32'h10);
        check("wr_ram_data", 32'(bus.ram_data), 32'hA5);
        next_cycle();
        set_req(2, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("wr_rsp_id", 32'(bus.rsp_id), 32'd2);
        check("wr_rsp_we", 32'(bus.rsp_we), 32'd1);
        check("wr_rsp_data", 32'(bus.rsp_data), 32'hA5);
        check("rd_ram_we", 32'(bus.ram_we), 32'd0);
        next_cycle();
        bus.req_valid = '0;
        @(negedge clk);
        check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_rsp_we", 32'(bus.rsp_we), 32'd0);
        check("rd_rsp_data", 32'(bus.rsp_data), 32'hA5);
        next_cycle();

        // Park ownership on requester 3, go idle, then all request
        bus.req_valid = 4'b1000;
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        bus.req_valid = '1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("burst_seq[%0d]", i), 32'(grant_of(bus.req_ready)), 32'((i / 4) % 4));
            next_cycle();
        end
        bus.req_valid = '0;
        next_cycle();

        // Requester 1 holds two grants, then drops while 0 and 3 wait
        bus.req_valid = 4'b0010;
        repeat (2) begin
            @(negedge clk);
            check("yield_setup", 32'(bus.req_ready), 32'h2);
            next_cycle();
        end
        bus.req_valid = 4'b1001;
        @(negedge clk);
        check("yield_to_3", 32'(bus.req_ready), 32'h8);
        next_cycle();
        bus.req_valid = '0;
        next_cycle();

        // Sole requester across burst exhaustion
        bus.req_valid = 4'b1000;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i < 10) check("sole_ready", 32'(bus.req_ready), 32'h8);
            if (i > 0) begin
                check("sole_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("sole_rsp_id", 32'(bus.rsp_id), 32'd3);
            end
            next_cycle();
            if (i == 9) bus.req_valid = '0;
        end

        // Reset while requester 0 is being served
        set_req(0, 1'b0, 8'h10, 8'h00);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("pre_rst_grant", 32'(bus.req_ready), 32'h1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_ram_we", 32'(bus.ram_we), 32'd0);
        next_cycle();
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        next_cycle();
        bus.req_valid = '1;
        @(negedge clk);
        check("post_rst_grant0", 32'(bus.req_ready), 32'h1);
        next_cycle();

        // Randomized traffic, small address range for collisions, rare resets
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++)
                set_req(i, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
            rst = ($urandom_range(0, 199) != 0);
            next_cycle();
        end
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
